// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule applied to every captured request.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_MERGE  = 2'd2
    } lsu_state_e;

    // Size 3 is not a real access size, so it is always reported as an error.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends load data from a memory
// word, and builds the merged word for sub-word stores (little-endian lanes).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = word[{offset, 3'b000} +: 8];
        halfLane = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: loadData = {{24{signedLoad & byteLane[7]}}, byteLane};
            SIZE_HALF: loadData = {{16{signedLoad & halfLane[15]}}, halfLane};
            default:   loadData = word;
        endcase
    end

    always_comb begin
        mergedWord = word;
        case (size)
            SIZE_BYTE: mergedWord[{offset, 3'b000} +: 8]    = wdata[7:0];
            SIZE_HALF: mergedWord[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default:   mergedWord = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a 32-word data memory: one request at a
// time, read-modify-write for sub-word stores, one-cycle registered response.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic        rspMisalign,
    output logic        memWen,
    output logic        memReadEn,
    output logic [4:0]  memAddress,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    lsu_state_e  state, nextState;
    logic        capWrite, capSigned;
    logic [1:0]  capSize;
    logic [6:0]  capAddr;
    logic [31:0] capWdata, mergeReg;
    logic [31:0] loadData, mergedWord;
    logic        misaligned, respond;
    logic        unusedAddrBits;

    // The memory only spans 128 bytes, so the upper address bits wrap away.
    assign unusedAddrBits = ^reqAddr[31:7];
    assign reqReady       = (state == LSU_IDLE);
    assign misaligned     = isMisaligned(capSize, capAddr[1:0]);

    lsu_lane_align u_align (
        .size       (capSize),
        .signedLoad (capSigned),
        .offset     (capAddr[1:0]),
        .word       (memDataOut),
        .wdata      (capWdata),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= LSU_IDLE;
            capWrite    <= 1'b0;
            capSigned   <= 1'b0;
            capSize     <= 2'd0;
            capAddr     <= 7'd0;
            capWdata    <= 32'd0;
            mergeReg    <= 32'd0;
            rspValid    <= 1'b0;
            rspData     <= 32'd0;
            rspMisalign <= 1'b0;
        end else begin
            state       <= nextState;
            rspValid    <= respond;
            rspData     <= (respond && !capWrite && !misaligned) ? loadData : 32'd0;
            rspMisalign <= respond && misaligned;
            if (reqValid && reqReady) begin
                capWrite  <= reqWrite;
                capSigned <= reqSigned;
                capSize   <= reqSize;
                capAddr   <= reqAddr[6:0];
                capWdata  <= reqWdata;
            end
            if (state == LSU_ACCESS && nextState == LSU_MERGE)
                mergeReg <= mergedWord;
        end
    end

    // Memory strobes are decoded from state only, so an async reset clears them at once.
    always_comb begin
        nextState  = state;
        memWen     = 1'b0;
        memReadEn  = 1'b0;
        memAddress = 5'd0;
        memDataIn  = 32'd0;
        respond    = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (reqValid)
                    nextState = LSU_ACCESS;
            end
            LSU_ACCESS: begin
                if (misaligned) begin
                    respond   = 1'b1;
                    nextState = LSU_IDLE;
                end else if (!capWrite) begin
                    memReadEn  = 1'b1;
                    memAddress = capAddr[6:2];
                    respond    = 1'b1;
                    nextState  = LSU_IDLE;
                end else if (capSize == SIZE_WORD) begin
                    memWen     = 1'b1;
                    memAddress = capAddr[6:2];
                    memDataIn  = capWdata;
                    respond    = 1'b1;
                    nextState  = LSU_IDLE;
                end else begin
                    memReadEn  = 1'b1;
                    memAddress = capAddr[6:2];
                    nextState  = LSU_MERGE;
                end
            end
            LSU_MERGE: begin
                memWen     = 1'b1;
                memAddress = capAddr[6:2];
                memDataIn  = mergeReg;
                respond    = 1'b1;
                nextState  = LSU_IDLE;
            end
            default: nextState = LSU_IDLE;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the EX/MEM pipeline register and the 32-word data memory. Accepts one byte, halfword or word load/store per request, turns sub-word stores into read-modify-write sequences on the word-only memory, and aligns and extends load data. Produces a one-cycle response for the MEM/WB register and stalls the pipeline while busy.

## Interface
- No parameters. Memory is fixed at 32 words × 32 bits (5-bit word address).
- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `reqValid`  in  1  request present
- `reqReady`  out  1  unit can accept; request accepted on edge where `reqValid & reqReady`
- `reqWrite`  in  1  1 = store, 0 = load
- `reqSize`  in  2  0 byte, 1 half, 2 word, 3 illegal
- `reqSigned`  in  1  loads only: 1 sign-extend, 0 zero-extend
- `reqAddr`  in  32  byte address; bits [31:7] ignored
- `reqWdata`  in  32  store data, right-justified
- `rspValid`  out  1  one-cycle completion pulse
- `rspData`  out  32  extended load data; 0 for stores and errors
- `rspMisalign`  out  1  qualifies `rspValid`: request was misaligned or illegal size
- `memWen`  out  1  memory write strobe
- `memReadEn`  out  1  memory read enable
- `memAddress`  out  5  word address = captured `reqAddr[6:2]`
- `memDataIn`  out  32  write data to memory
- `memDataOut`  in  32  combinational read data from memory

## Operation
- States: IDLE, ACCESS, MERGE. `reqReady` = (state == IDLE).
- IDLE: on accept, capture write/size/signed/addr/wdata; go ACCESS.
- Misalign check on captured request: half with addr[0]=1, word with addr[1:0]≠0, or size 3 → error. Error: ACCESS drives no strobes; return to IDLE; `rspValid=1`, `rspMisalign=1`, `rspData=0`.
- Load: ACCESS asserts `memReadEn`; sample `memDataOut` at end of cycle. Lane select little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half = bits [16·addr[1]+15:16·addr[1]]. Extend per `reqSigned`; register into `rspData`; → IDLE.
- Word store: ACCESS asserts `memWen`, `memDataIn=reqWdata`; → IDLE.
- Sub-word store: ACCESS asserts `memReadEn`, registers merged word (old word with addressed lane replaced by `reqWdata[7:0]` / `[15:0]`); → MERGE. MERGE asserts `memWen` with merged word; → IDLE.
- `memWen`, `memReadEn` never both high. Outside their states all memory outputs are 0.
- Response: `rspValid` pulses in the cycle after the final ACCESS/MERGE cycle; store response has `rspData=0`, `rspMisalign=0`.
- While busy, `reqValid` is ignored; requester holds request stable until accepted.

## Timing
- Accept at edge 0. Load / word store / error: ACCESS cycle 1, `rspValid` cycle 2. Sub-word store: ACCESS 1, MERGE 2, `rspValid` cycle 3.
- `reqReady` returns high in the `rspValid` cycle; back-to-back accept allowed there. Throughput one op per 2 cycles (3 for sub-word stores).
- Store followed immediately by load to same word returns the new data; the write completes before the store response.
- Reset values: state IDLE, `reqReady=1`, `rspValid=0`, `rspData=0`, `rspMisalign=0`, all `mem*` outputs 0.
- Reset mid-operation: outputs return to reset values immediately; in-flight request dropped with no response. Reset in MERGE suppresses the write. Memory contents are not touched by reset.
- Address wrap: `reqAddr=0x80` addresses word 0.

## Structure
- Package `lsu_pkg`: size encodings `SIZE_BYTE/SIZE_HALF/SIZE_WORD`, state encoding `LSU_IDLE/LSU_ACCESS/LSU_MERGE`.
- Sub-module `lsu_lane_align`: combinational load extract/extend and store merge from (size, signed, addr[1:0], word, wdata). The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 → memWen cycle 1, rspValid cycle 2, load rspData 0xDEADBEEF.
- Memory word 4 = 0x11223344; sb 0xAA to 0x13 → read cycle 1, write 0xAA223344 cycle 2, rspValid cycle 3.
- Word 4 = 0x8000F080: lb 0x10 → 0xFFFFFF80; lbu 0x10 → 0x00000080; lh 0x12 → 0xFFFF8000; lhu 0x10 → 0x0000F080.
- lw 0x11, lh 0x13, size 3 → rspMisalign=1, rspData=0, memWen/memReadEn never asserted.
- Back-to-back: sh 0x5555 to 0x0E then lw 0x0C accepted in the sh response cycle → lw returns upper half 0x5555.
- Drop `rstn` during MERGE → memWen 0 immediately, no rspValid, word unchanged; reqReady=1 after release.
